gg_start_code_detect: RTL and testbench

// Consumes the emulation-removed big-endian byte stream and its per-byte flags from gg_emulation_remove.

---
 rtl/gg_start_code_detect.sv | 123 ++++++++++++
 tb/tb_gg_start_code_detect.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gg_start_code_detect.sv
// Start-code (00 00 01) finder for the emulation-removed byte stream.
// GG_SC_STATS_EN builds the sc_count / fzb_err statistics.
module gg_start_code_detect #(
  parameter int WIDTH      = 128,
  parameter int BYTE_WIDTH = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      iport,
  input  logic [BYTE_WIDTH-1:0] iflag,
  input  logic                  iport_valid,
  output logic                  iport_ready,
  output logic [WIDTH-1:0]      oport,
  output logic [BYTE_WIDTH-1:0] osc,
  output logic [BYTE_WIDTH-1:0] oflag,
  output logic                  oport_valid,
  input  logic                  oport_ready,
  output logic                  nal_hdr_valid,
  output logic [1:0]            nal_ref_idc,
  output logic [4:0]            nal_type,
  output logic                  fzb_err,
  output logic [15:0]           sc_count
);

  localparam int WIN = BYTE_WIDTH + 3;

  logic [7:0]            hist0;
  logic [7:0]            hist1;
  logic [7:0]            hist2;
  logic [2:0]            hist_flag;
  logic [7:0]            win [WIN];
  logic [WIN-1:0]        wflag;
  logic [BYTE_WIDTH-1:0] osc_next;
  logic [6:0]            hdr_next;
  logic                  accept;

  assign iport_ready   = ~oport_valid | oport_ready;
  assign accept        = iport_valid & iport_ready;
  assign nal_hdr_valid = oport_valid & (|osc);

  // window index 0 is the oldest history byte
  always_comb begin
    win[0]   = hist0;
    win[1]   = hist1;
    win[2]   = hist2;
    wflag[2:0] = hist_flag;
    for (int k = 0; k < BYTE_WIDTH; k++) begin
      win[k+3]   = iport[WIDTH-1-8*k -: 8];
      wflag[k+3] = iflag[BYTE_WIDTH-1-k];
    end
  end

  // scan latest to earliest so the earliest header wins
  always_comb begin
    osc_next = '0;
    hdr_next = '0;
    for (int k = BYTE_WIDTH - 1; k >= 0; k--) begin
      if (win[k] == 8'h00 && win[k+1] == 8'h00 &&
          win[k+2] == 8'h01 && wflag[k+2 -: 3] == 3'b000) begin
        osc_next[BYTE_WIDTH-1-k] = 1'b1;
        hdr_next = win[k+3][6:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oport_valid <= 1'b0;
      oport       <= '0;
      oflag       <= '0;
      osc         <= '0;
      nal_ref_idc <= '0;
      nal_type    <= '0;
      hist0       <= 8'hFF;
      hist1       <= 8'hFF;
      hist2       <= 8'hFF;
      hist_flag   <= '0;
    end else if (accept) begin
      oport_valid <= 1'b1;
      oport       <= iport;
      oflag       <= iflag;
      osc         <= osc_next;
      nal_ref_idc <= hdr_next[6:5];
      nal_type    <= hdr_next[4:0];
      hist0       <= win[WIN-3];
      hist1       <= win[WIN-2];
      hist2       <= win[WIN-1];
      hist_flag   <= wflag[WIN-1 -: 3];
    end else if (oport_ready) begin
      oport_valid <= 1'b0;
    end
  end

`ifdef GG_SC_STATS_EN
  logic       fzb_next;
  logic [4:0] sc_inc;

  always_comb begin
    fzb_next = 1'b0;
    sc_inc   = '0;
    for (int k = 0; k < BYTE_WIDTH; k++) begin
      if (osc_next[BYTE_WIDTH-1-k]) begin
        sc_inc = sc_inc + 5'd1;
        if (win[k+3][7]) fzb_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fzb_err  <= 1'b0;
      sc_count <= '0;
    end else if (accept) begin
      fzb_err  <= fzb_err | fzb_next;
      sc_count <= sc_count + {11'd0, sc_inc};
    end
  end
`else
  assign fzb_err  = 1'b0;
  assign sc_count = '0;
`endif

endmodule

// File: tb/tb_gg_start_code_detect.sv
// Randomized bench for gg_start_code_detect against a byte-stream model.
// Honours GG_SC_STATS_EN for the statistics outputs.
module tb_gg_start_code_detect;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] iport;
  logic [15:0]  iflag;
  logic         iport_valid;
  logic         iport_ready;
  logic [127:0] oport;
  logic [15:0]  osc;
  logic [15:0]  oflag;
  logic         oport_valid;
  logic         oport_ready;
  logic         nal_hdr_valid;
  logic [1:0]   nal_ref_idc;
  logic [4:0]   nal_type;
  logic         fzb_err;
  logic [15:0]  sc_count;

  gg_start_code_detect dut (
    .clk(clk), .reset(reset),
    .iport(iport), .iflag(iflag),
    .iport_valid(iport_valid), .iport_ready(iport_ready),
    .oport(oport), .osc(osc), .oflag(oflag),
    .oport_valid(oport_valid), .oport_ready(oport_ready),
    .nal_hdr_valid(nal_hdr_valid),
    .nal_ref_idc(nal_ref_idc), .nal_type(nal_type),
    .fzb_err(fzb_err), .sc_count(sc_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // whole accepted stream since reset, seeded with the FF history
  logic [7:0]   bq[$];
  logic         fq[$];
  logic         mv;
  logic [127:0] m_port;
  logic [15:0]  m_flag;
  logic [15:0]  m_osc;
  logic [7:0]   m_hdr;
  logic         m_fzb;
  logic [15:0]  m_cnt;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    bq = '{8'hFF, 8'hFF, 8'hFF};
    fq = '{1'b0, 1'b0, 1'b0};
    mv = 1'b0;
    m_fzb = 1'b0;
    m_cnt = '0;
  endfunction

  function automatic void model_load(input logic [127:0] d,
                                     input logic [15:0] f);
    int base;
    int first;
    base  = bq.size();
    first = -1;
    for (int k = 0; k < 16; k++) begin
      bq.push_back(d[127-8*k -: 8]);
      fq.push_back(f[15-k]);
    end
    m_osc = '0;
    for (int k = 0; k < 16; k++) begin
      int p;
      p = base + k;
      if (bq[p-3] == 8'h00 && bq[p-2] == 8'h00 && bq[p-1] == 8'h01 &&
          !fq[p-3] && !fq[p-2] && !fq[p-1]) begin
        m_osc[15-k] = 1'b1;
        m_cnt = m_cnt + 16'd1;
        if (bq[p][7]) m_fzb = 1'b1;
        if (first < 0) first = k;
      end
    end
    m_hdr  = (first >= 0) ? bq[base+first] : 8'h00;
    m_port = d;
    m_flag = f;
    mv     = 1'b1;
  endfunction

  task automatic check_outputs();
    chk("ovalid", oport_valid, mv);
    if (mv) begin
      chk("oport", oport, m_port);
      chk("oflag", oflag, m_flag);
      chk("osc", osc, m_osc);
      chk("nhv", nal_hdr_valid, m_osc != 0);
      if (m_osc != 0) begin
        chk("nal_type", nal_type, m_hdr[4:0]);
        chk("nal_ref", nal_ref_idc, m_hdr[6:5]);
      end
    end else begin
      chk("nhv_idle", nal_hdr_valid, 1'b0);
    end
`ifdef GG_SC_STATS_EN
    chk("fzb", fzb_err, m_fzb);
    chk("sc_count", sc_count, m_cnt);
`else
    chk("fzb_off", fzb_err, 1'b0);
    chk("sc_off", sc_count, 16'h0);
`endif
  endtask

  task automatic cyc(input logic v, input logic [127:0] d,
                     input logic [15:0] f, input logic r);
    logic fire;
    @(negedge clk);
    check_outputs();
    iport_valid = v;
    iport       = d;
    iflag       = f;
    oport_ready = r;
    #1;
    chk("iready", iport_ready, !mv || r);
    fire = v && (!mv || r);
    @(posedge clk);
    if (fire) model_load(d, f);
    else if (r) mv = 1'b0;
  endtask

  function automatic logic [7:0] rbyte();
    int s;
    s = $urandom_range(0, 9);
    if (s < 5) return 8'h00;
    if (s < 7) return 8'h01;
    return 8'($urandom);
  endfunction

  logic [127:0] w;
  logic [127:0] w2;
  logic [15:0]  rf;
  logic [15:0]  cnt0;

  initial begin
    reset       = 1'b1;
    iport_valid = 1'b0;
    iport       = '0;
    iflag       = '0;
    oport_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ovalid", oport_valid, 1'b0);
    chk("rst_oport", oport, 128'h0);
    chk("rst_osc", osc, 16'h0);
    chk("rst_iready", iport_ready, 1'b1);
    chk("rst_cnt", sc_count, 16'h0);
    reset = 1'b0;

    // single start code
    cyc(1, 128'h00000165_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0, 1);
    #1;
    chk("t1_osc", osc, 16'h1000);
    chk("t1_type", nal_type, 5'd5);
    chk("t1_ref", nal_ref_idc, 2'd3);
    chk("t1_nhv", nal_hdr_valid, 1'b1);
`ifdef GG_SC_STATS_EN
    chk("t1_cnt", sc_count, 16'd1);
`endif

    // 2|1 split
    cyc(1, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA0000, 16'h0, 1);
    #1 chk("t2a_osc", osc, 16'h0);
    cyc(0, '0, '0, 1);
    cyc(1, 128'h0167AAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0, 1);
    #1;
    chk("t2b_osc", osc, 16'h4000);
    chk("t2b_type", nal_type, 5'd7);

    // 3|0 split
    cyc(1, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AA000001, 16'h0, 1);
    cyc(1, 128'h68AAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0, 1);
    #1;
    chk("t3_osc", osc, 16'h8000);
    chk("t3_type", nal_type, 5'd8);
    chk("t3_ref", nal_ref_idc, 2'd3);

    // flagged 01 byte suppresses detection
    cnt0 = m_cnt;
    cyc(1, 128'h00000141_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h2000, 1);
    #1;
    chk("t4_osc", osc, 16'h0);
    chk("t4_nhv", nal_hdr_valid, 1'b0);
`ifdef GG_SC_STATS_EN
    chk("t4_cnt", sc_count, cnt0);
`endif

    // two codes in one word, forbidden-zero bit set on the second
    cyc(1, 128'h00000106_000001E5_AAAAAAAA_AAAAAAAA, 16'h0, 1);
    #1;
    chk("t5_osc", osc, 16'h1100);
    chk("t5_type", nal_type, 5'd6);
`ifdef GG_SC_STATS_EN
    chk("t5_fzb", fzb_err, 1'b1);
    chk("t5_cnt", sc_count, cnt0 + 16'd2);
`endif

    // backpressure
    w  = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    w2 = 128'h00000109_0F0E0D0C_0B0A0908_07060504;
    cyc(1, w, 16'h0, 1);
    repeat (4) cyc(1, w2, 16'h0, 0);
    cyc(1, w2, 16'h0, 1);
    cyc(0, '0, '0, 1);
    cyc(0, '0, '0, 1);

    // mid-stream reset with a pending 00 00 history
    cyc(1, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA0000, 16'h0, 0);
    @(negedge clk);
    reset       = 1'b1;
    iport_valid = 1'b0;
    #1;
    chk("mr_ovalid", oport_valid, 1'b0);
    chk("mr_osc", osc, 16'h0);
    chk("mr_oport", oport, 128'h0);
    chk("mr_iready", iport_ready, 1'b1);
    chk("mr_cnt", sc_count, 16'h0);
    chk("mr_fzb", fzb_err, 1'b0);
    model_reset();
    @(posedge clk);
    reset = 1'b0;
    cyc(1, 128'h0167AAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0, 1);
    #1 chk("mr_nofalse", osc, 16'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 16; b++) w[127-8*b -: 8] = rbyte();
      rf = '0;
      for (int b = 0; b < 16; b++)
        if ($urandom_range(0, 9) == 0) rf[b] = 1'b1;
      cyc($urandom_range(0, 3) != 0, w, rf, $urandom_range(0, 3) != 0);
    end
    cyc(0, '0, '0, 1);
    cyc(0, '0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
